// File: rtl/i2c_ctrl_pkg.sv
// Shared types and constants for the I2C write-only bus controller.
package i2c_ctrl_pkg;

  localparam int   BITS_PER_BYTE = 8;
  localparam logic WRITE_BIT     = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ACK1,
    DATA,
    ACK2,
    STOP,
    DONE
  } state_t;

endpackage

// File: rtl/clock_edge_detector.sv
// Registers ClockI2C once and flags its rising/falling edges from the registered and previous samples.
module clock_edge_detector (
  input  logic clock,
  input  logic Reset,
  input  logic ClockI2C,
  output logic Rise,
  output logic Fall,
  output logic Level
);

  logic prev;

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      Level <= 1'b0;
      prev  <= 1'b0;
    end else begin
      Level <= ClockI2C;
      prev  <= Level;
    end
  end

  assign Rise = Level & ~prev;
  assign Fall = ~Level & prev;

endmodule

// File: rtl/i2c_bus_controller.sv
// Single-byte I2C write master (address + one data byte); bus actions follow ClockI2C edges one cycle after detection.
// Optional watchdog on a stalled ClockI2C is built when I2C_CTRL_TIMEOUT_EN is defined.
module i2c_bus_controller
  import i2c_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [6:0] Address,
  input  logic [7:0] Data,
  input  logic       ClockI2C,
  output logic       EnableClock,
  input  logic       SDAIn,
  output logic       SCL,
  output logic       SDAOut,
  output logic       SDAOE,
  output logic       Busy,
  output logic       Done,
  output logic       AckError
);

  localparam int CNT_W = $clog2(BITS_PER_BYTE);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS_PER_BYTE - 1);

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t                   state, state_n;
  logic [BITS_PER_BYTE-1:0] shift_q, shift_n;
  logic [BITS_PER_BYTE-1:0] data_q, data_n;
  logic [CNT_W-1:0]         bit_cnt, cnt_n;
  logic                     byte_done, byte_done_n;
  logic                     ack_err, ack_err_n;
  logic                     stop_scl, stop_scl_n;
  logic                     rise, fall, level;
  logic                     busy;

  clock_edge_detector u_edge (
    .clock    (clock),
    .Reset    (Reset),
    .ClockI2C (ClockI2C),
    .Rise     (rise),
    .Fall     (fall),
    .Level    (level)
  );

  assign busy = (state != IDLE) && (state != DONE);

`ifdef I2C_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            timeout;

  // Any ClockI2C edge proves the generator is alive; only consecutive quiet cycles count.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset)
      wd_cnt <= '0;
    else if (!busy || rise || fall)
      wd_cnt <= '0;
    else if (!timeout)
      wd_cnt <= wd_cnt + 1'b1;
  end

  assign timeout = busy && (wd_cnt >= WD_W'(TIMEOUT_CYCLES));
`endif

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      shift_q   <= '0;
      data_q    <= '0;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
      ack_err   <= 1'b0;
      stop_scl  <= 1'b0;
    end else begin
      state     <= state_n;
      shift_q   <= shift_n;
      data_q    <= data_n;
      bit_cnt   <= cnt_n;
      byte_done <= byte_done_n;
      ack_err   <= ack_err_n;
      stop_scl  <= stop_scl_n;
    end
  end

  always_comb begin
    state_n     = state;
    shift_n     = shift_q;
    data_n      = data_q;
    cnt_n       = bit_cnt;
    byte_done_n = byte_done;
    ack_err_n   = ack_err;
    stop_scl_n  = stop_scl;
    SCL         = 1'b1;
    SDAOut      = 1'b1;
    SDAOE       = 1'b0;
    EnableClock = 1'b1;

    case (state)
      IDLE: begin
        EnableClock = 1'b0;
        if (Start) begin
          shift_n     = {Address, WRITE_BIT};
          data_n      = Data;
          ack_err_n   = 1'b0;
          cnt_n       = '0;
          byte_done_n = 1'b0;
          stop_scl_n  = 1'b0;
          state_n     = START;
        end
      end

      START: begin
        SDAOE  = 1'b1;
        SDAOut = 1'b0;
        if (fall) state_n = ADDR;
      end

      ADDR, DATA: begin
        SCL    = level;
        SDAOE  = 1'b1;
        SDAOut = shift_q[BITS_PER_BYTE-1];
        if (rise) begin
          cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) byte_done_n = 1'b1;
        end else if (fall) begin
          // After the eighth rising edge, the next falling edge hands the bus to the slave.
          if (byte_done) begin
            byte_done_n = 1'b0;
            state_n     = (state == ADDR) ? ACK1 : ACK2;
          end else begin
            shift_n = {shift_q[BITS_PER_BYTE-2:0], 1'b0};
          end
        end
      end

      ACK1, ACK2: begin
        SCL = level;
        if (rise && SDAIn) begin
          ack_err_n = 1'b1;
        end else if (fall) begin
          if (state == ACK2 || ack_err) begin
            stop_scl_n = 1'b0;
            state_n    = STOP;
          end else begin
            shift_n = data_q;
            state_n = DATA;
          end
        end
      end

      STOP: begin
        SCL    = stop_scl;
        SDAOE  = 1'b1;
        SDAOut = 1'b0;
        if (rise)
          stop_scl_n = 1'b1;
        else if (fall && stop_scl)
          state_n = DONE;
      end

      DONE: begin
        EnableClock = 1'b0;
        state_n     = IDLE;
      end

      default: state_n = IDLE;
    endcase

`ifdef I2C_CTRL_TIMEOUT_EN
    if (timeout) begin
      ack_err_n = 1'b1;
      state_n   = DONE;
    end
`endif
  end

  assign Busy     = busy;
  assign Done     = (state == DONE);
  assign AckError = ack_err;

endmodule

// File: tb/tb_i2c_bus_controller.sv
// Bench for i2c_bus_controller: a baud-generator model drives ClockI2C, a bus monitor rebuilds bytes for a scoreboard.
module tb_i2c_bus_controller;

  localparam int CLOCK_FREQ = 10;
  localparam int BAUD_RATE  = 2;
  localparam int HALF       = CLOCK_FREQ / (2 * BAUD_RATE);

  logic       clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [6:0] Address = '0;
  logic [7:0] Data = '0;
  logic       ClockI2C;
  logic       SDAIn = 1'b0;
  logic       EnableClock, SCL, SDAOut, SDAOE, Busy, Done, AckError;

  int         checks = 0;
  int         fails = 0;
  bit         stall = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         done_cnt = 0;
  int         txn_bits = 0;
  logic [7:0] acc = '0;
  logic       scl_prev = 1'b1;
  int         gen_cnt = 0;

  always #5 clock = ~clock;

  i2c_bus_controller #(.TIMEOUT_CYCLES(16)) dut (
    .clock       (clock),
    .Reset       (Reset),
    .Start       (Start),
    .Address     (Address),
    .Data        (Data),
    .ClockI2C    (ClockI2C),
    .EnableClock (EnableClock),
    .SDAIn       (SDAIn),
    .SCL         (SCL),
    .SDAOut      (SDAOut),
    .SDAOE       (SDAOE),
    .Busy        (Busy),
    .Done        (Done),
    .AckError    (AckError)
  );

  // Square-wave generator model, gated by EnableClock; stall freezes its output.
  always @(posedge clock) begin
    if (Reset || !EnableClock) begin
      gen_cnt  <= 0;
      ClockI2C <= 1'b0;
    end else if (!stall) begin
      if (gen_cnt == HALF - 1) begin
        gen_cnt  <= 0;
        ClockI2C <= ~ClockI2C;
      end else begin
        gen_cnt <= gen_cnt + 1;
      end
    end
  end

  always @(negedge clock) begin
    if (Done) done_cnt++;
    if (Reset || !Busy) begin
      txn_bits = 0;
      acc      = '0;
    end else if (SCL && !scl_prev && SDAOE) begin
      acc = {acc[6:0], SDAOut};
      txn_bits++;
      if (txn_bits % 8 == 0) obs_q.push_back(acc);
    end
    scl_prev = SCL;
  end

  task automatic start_txn(input logic [6:0] a, input logic [7:0] d);
    @(negedge clock);
    Address = a;
    Data    = d;
    Start   = 1'b1;
    @(negedge clock);
    Start   = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      cycles++;
      if (Done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_bits(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (txn_bits >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (SCL !== 1'b1)         begin fails++; $display("FAIL reset_scl got %b want 1", SCL); end
    checks++; if (SDAOE !== 1'b0)       begin fails++; $display("FAIL reset_sdaoe got %b want 0", SDAOE); end
    checks++; if (SDAOut !== 1'b1)      begin fails++; $display("FAIL reset_sdaout got %b want 1", SDAOut); end
    checks++; if (EnableClock !== 1'b0) begin fails++; $display("FAIL reset_enclk got %b want 0", EnableClock); end
    checks++; if (Busy !== 1'b0)        begin fails++; $display("FAIL reset_busy got %b want 0", Busy); end
    checks++; if (Done !== 1'b0)        begin fails++; $display("FAIL reset_done got %b want 0", Done); end
    checks++; if (AckError !== 1'b0)    begin fails++; $display("FAIL reset_ackerr got %b want 0", AckError); end
    Reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_write;
    bit ok; int cyc; int d0; logic [7:0] e, o;
    d0 = done_cnt;
    SDAIn = 1'b0;
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA5);
    start_txn(7'h50, 8'hA5);
    checks++; if (Busy !== 1'b1) begin fails++; $display("FAIL write_busy_after_start got %b want 1", Busy); end
    wait_done(400, ok, cyc);
    checks++; if (!ok) begin fails++; $display("FAIL write_done_timeout got none want Done within 400 cycles"); end
    repeat (3) @(negedge clock);
    checks++; if (AckError !== 1'b0) begin fails++; $display("FAIL write_ackerr got %b want 0", AckError); end
    checks++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL write_done_pulses got %0d want 1", done_cnt - d0); end
    checks++; if (Busy !== 1'b0) begin fails++; $display("FAIL write_busy_after got %b want 0", Busy); end
    checks++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL write_byte_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin fails++; $display("FAIL write_byte got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_nack;
    bit ok; int cyc; int d0; logic [7:0] e, o;
    d0 = done_cnt;
    SDAIn = 1'b1;
    exp_q.push_back(8'hA0);
    start_txn(7'h50, 8'hA5);
    wait_done(400, ok, cyc);
    checks++; if (!ok) begin fails++; $display("FAIL nack_done_timeout got none want Done within 400 cycles"); end
    repeat (3) @(negedge clock);
    SDAIn = 1'b0;
    checks++; if (AckError !== 1'b1) begin fails++; $display("FAIL nack_ackerr got %b want 1", AckError); end
    checks++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL nack_done_pulses got %0d want 1", done_cnt - d0); end
    checks++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL nack_byte_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin fails++; $display("FAIL nack_byte got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_busy_ignore;
    bit ok; int cyc; logic [7:0] e, o;
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA5);
    start_txn(7'h50, 8'hA5);
    repeat (10) @(negedge clock);
    Address = 7'h11; Data = 8'hFF; Start = 1'b1;
    @(negedge clock);
    Start = 1'b0;
    checks++; if (Busy !== 1'b1) begin fails++; $display("FAIL ignore_busy got %b want 1", Busy); end
    wait_done(400, ok, cyc);
    checks++; if (!ok) begin fails++; $display("FAIL ignore_done_timeout got none want Done within 400 cycles"); end
    repeat (3) @(negedge clock);
    checks++; if (AckError !== 1'b0) begin fails++; $display("FAIL ignore_ackerr got %b want 0", AckError); end
    checks++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL ignore_byte_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin fails++; $display("FAIL ignore_byte got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid;
    bit ok; int cyc; logic [7:0] e, o;
    exp_q.push_back(8'hA0);
    start_txn(7'h50, 8'hA5);
    wait_bits(11, ok);
    checks++; if (!ok) begin fails++; $display("FAIL rstmid_reach_data got none want 11 bits within 400 cycles"); end
    #2 Reset = 1'b1;
    #1;
    checks++; if (SCL !== 1'b1)         begin fails++; $display("FAIL rstmid_scl got %b want 1", SCL); end
    checks++; if (SDAOE !== 1'b0)       begin fails++; $display("FAIL rstmid_sdaoe got %b want 0", SDAOE); end
    checks++; if (Busy !== 1'b0)        begin fails++; $display("FAIL rstmid_busy got %b want 0", Busy); end
    checks++; if (EnableClock !== 1'b0) begin fails++; $display("FAIL rstmid_enclk got %b want 0", EnableClock); end
    repeat (2) @(negedge clock);
    Reset = 1'b0;
    repeat (2) @(negedge clock);
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA5);
    start_txn(7'h50, 8'hA5);
    wait_done(400, ok, cyc);
    checks++; if (!ok) begin fails++; $display("FAIL rstmid_rerun_timeout got none want Done within 400 cycles"); end
    repeat (3) @(negedge clock);
    checks++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL rstmid_byte_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin fails++; $display("FAIL rstmid_byte got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

`ifdef I2C_CTRL_TIMEOUT_EN
  task automatic test_timeout;
    bit ok; int cyc;
    start_txn(7'h50, 8'hA5);
    wait_bits(3, ok);
    checks++; if (!ok) begin fails++; $display("FAIL timeout_reach_addr got none want 3 bits within 400 cycles"); end
    stall = 1'b1;
    wait_done(100, ok, cyc);
    checks++; if (!ok) begin fails++; $display("FAIL timeout_done got none want Done within 100 cycles"); end
    checks++; if (cyc < 16 || cyc > 20) begin fails++; $display("FAIL timeout_cycles got %0d want 16..20", cyc); end
    checks++; if (AckError !== 1'b1) begin fails++; $display("FAIL timeout_ackerr got %b want 1", AckError); end
    checks++; if (SDAOE !== 1'b0 || SCL !== 1'b1) begin fails++; $display("FAIL timeout_bus got sdaoe=%b scl=%b want 0 1", SDAOE, SCL); end
    stall = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (obs_q.size() != 0) begin fails++; $display("FAIL timeout_byte_count got %0d want 0", obs_q.size()); end
    exp_q.delete(); obs_q.delete();
  endtask
`else
  task automatic test_stall;
    bit ok; int cyc; int d0; logic [7:0] e, o;
    d0 = done_cnt;
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA5);
    start_txn(7'h50, 8'hA5);
    wait_bits(3, ok);
    checks++; if (!ok) begin fails++; $display("FAIL stall_reach_addr got none want 3 bits within 400 cycles"); end
    stall = 1'b1;
    repeat (60) @(negedge clock);
    checks++; if (Busy !== 1'b1) begin fails++; $display("FAIL stall_busy got %b want 1", Busy); end
    checks++; if (done_cnt != d0) begin fails++; $display("FAIL stall_done_pulses got %0d want 0", done_cnt - d0); end
    checks++; if (AckError !== 1'b0) begin fails++; $display("FAIL stall_ackerr got %b want 0", AckError); end
    stall = 1'b0;
    wait_done(400, ok, cyc);
    checks++; if (!ok) begin fails++; $display("FAIL stall_resume_timeout got none want Done within 400 cycles"); end
    repeat (3) @(negedge clock);
    checks++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL stall_byte_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin fails++; $display("FAIL stall_byte got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask
`endif

  task automatic test_back_to_back;
    bit ok; int cyc; logic [7:0] e, o;
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h3C);
    start_txn(7'h50, 8'hA5);
    wait_done(400, ok, cyc);
    checks++; if (!ok) begin fails++; $display("FAIL b2b_first_timeout got none want Done within 400 cycles"); end
    // Start is raised while Done is showing, and held into the following IDLE cycle.
    Address = 7'h22; Data = 8'h3C; Start = 1'b1;
    @(negedge clock);
    checks++; if (Busy !== 1'b0) begin fails++; $display("FAIL b2b_not_accepted_in_done got busy=%b want 0", Busy); end
    @(negedge clock);
    Start = 1'b0;
    checks++; if (Busy !== 1'b1) begin fails++; $display("FAIL b2b_accepted_in_idle got busy=%b want 1", Busy); end
    wait_done(400, ok, cyc);
    checks++; if (!ok) begin fails++; $display("FAIL b2b_second_timeout got none want Done within 400 cycles"); end
    repeat (3) @(negedge clock);
    checks++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL b2b_byte_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin fails++; $display("FAIL b2b_byte got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_write();
    test_nack();
    test_write();
    test_busy_ignore();
    test_reset_mid();
`ifdef I2C_CTRL_TIMEOUT_EN
    test_timeout();
`else
    test_stall();
`endif
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got still running want finished by 500000");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/i2c_bus_controller.md
I2C_BUS_CONTROLLER -- requirements
Module: i2c_bus_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: clock cycles allowed between ClockI2C edges while busy.
REQ-002 SHALL have port clock, input, 1: system clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port Start, input, 1: transaction request, sampled every clock.
REQ-005 SHALL have port Address, input, 7: target address, latched when Start is accepted.
REQ-006 SHALL have port Data, input, 8: write byte, latched when Start is accepted.
REQ-007 SHALL have port ClockI2C, input, 1: square wave from the SquareWaveGenerator baud generator.
REQ-008 SHALL have port EnableClock, output, 1: drives the generator's Enable.
REQ-009 SHALL have port SDAIn, input, 1: sampled bus SDA.
REQ-010 SHALL have ports SCL (output, 1), SDAOut (output, 1) and SDAOE (output, 1): open-drain bus drive; SDAOE=0 releases SDA.
REQ-011 SHALL have ports Busy (output, 1), Done (output, 1; one-cycle pulse) and AckError (output, 1; sticky NACK/timeout flag).

Function
REQ-012 SHALL register ClockI2C once and detect rising/falling edges from the registered and previous values; edge-driven actions occur in the cycle after detection.
REQ-013 SHALL implement states IDLE, START, ADDR, ACK1, DATA, ACK2, STOP, DONE.
REQ-014 IDLE: Start=1 with Busy=0 SHALL latch shift register={Address,1'b0} and Data, clear AckError, and enter START; Busy SHALL be 1 from the next cycle.
REQ-015 Start while Busy=1 SHALL be ignored, with no latching.
REQ-016 START: SHALL drive SDA low (SDAOE=1, SDAOut=0) with SCL=1 and EnableClock=1; the first falling edge enters ADDR.
REQ-017 In ADDR, DATA, ACK1 and ACK2, SCL SHALL equal registered ClockI2C; outside them SCL SHALL be 1.
REQ-018 ADDR/DATA: SHALL present bits MSB first; each falling edge shifts one bit; a 3-bit counter advances on each rising edge; wrapping 7->0 enters ACK1/ACK2 at the next falling edge.
REQ-019 ACK1/ACK2: SHALL hold SDAOE=0 and sample SDAIn on the rising edge; 0 = ACK.
REQ-020 ACK1 with ACK SHALL load Data and enter DATA; NACK SHALL set AckError and enter STOP, skipping DATA.
REQ-021 ACK2 SHALL enter STOP on the next falling edge; a NACK SHALL set AckError.
REQ-022 STOP: SHALL drive SDA low, raise SCL at the next rising edge, then release SDA (SDAOE=0) at the following falling edge and enter DONE.
REQ-023 DONE: SHALL pulse Done for exactly one cycle, deassert EnableClock and Busy, and return to IDLE.

Reset
REQ-024 Reset SHALL immediately force IDLE with SCL=1, SDAOE=0, SDAOut=1, EnableClock=0, Busy=0, Done=0, AckError=0, counters and shift register at 0, including mid-transaction.

Configuration
REQ-025 With I2C_CTRL_TIMEOUT_EN defined, a watchdog SHALL count cycles without a ClockI2C edge while Busy=1; on reaching TIMEOUT_CYCLES it SHALL set AckError, release SDA, set SCL=1 and enter DONE.
REQ-026 Without I2C_CTRL_TIMEOUT_EN, no watchdog logic SHALL exist and a stalled ClockI2C SHALL hold the current state indefinitely.

Structure
REQ-027 Package i2c_ctrl_pkg SHALL hold the state enum, BITS_PER_BYTE=8 and WRITE_BIT=1'b0.
REQ-028 Edge detection SHALL be a sub-module clock_edge_detector (inputs clock, Reset, ClockI2C; outputs Rise, Fall).

Verification
REQ-029 Instantiate with SquareWaveGenerator (BaudRate=2, ClockFrequency=10); Address=7'h50, Data=8'hA5, SDAIn=0 on both ACKs -> SDA bits 1010_0000 then 1010_0101, AckError=0, one Done pulse, Busy low after.
REQ-030 SDAIn=1 during ACK1 -> AckError=1, no DATA bits driven, STOP issued, Done pulses.
REQ-031 Start pulsed again during ADDR with Address=7'h11 -> ignored; transaction still sends 0xA0.
REQ-032 Reset asserted mid-DATA bit 3 -> same cycle SCL=1, SDAOE=0, Busy=0, EnableClock=0; a new Start after release runs normally.
REQ-033 With I2C_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16, hold ClockI2C constant after START -> AckError=1 and Done at cycle 16.
REQ-034 Start asserted in the same cycle as DONE -> not accepted; accepted the cycle after, in IDLE.
